stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
- Downstream width-down-converter stage. Consumes one wide word per valid/ready handshake from the 32-bit pipeline register stage.
- Emits that word as a sequence of narrow beats on a valid/ready output, marking the final beat with out_last.
- Sits between the datapath pipeline and narrow links (byte-wide UART/SPI TX FIFOs). Supports partial words through a beat count.

Parameters:
- IN_WIDTH, 32: input word width. Must equal upstream DATA_WIDTH.
- OUT_WIDTH, 8: output beat width. IN_WIDTH % OUT_WIDTH == 0 is required; elaboration fails otherwise.
- LSB_FIRST, 1: 1 sends the least-significant slice first; 0 sends the most-significant slice first.
- Derived: RATIO = IN_WIDTH/OUT_WIDTH. CNT_W = max(1, $clog2(RATIO)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  IN_WIDTH  word to serialize
- in_nbeats  in  CNT_W  beats to send minus 1 (0 = one beat, RATIO-1 = full word)
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word this cycle
- out_data  out  OUT_WIDTH  current beat
- out_valid  out  1  beat valid
- out_last  out  1  current beat is the final beat of the word
- out_ready  in  1  downstream accepts beat

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low: rst_n.
- Reset values: out_valid=0, out_last=0, out_data=0, beat counter=0, shift register=0, state=IDLE. Consequently in_ready=1 once reset deasserts.
- States:
  - IDLE: no word held.
  - SEND: a word is held and out_valid=1.
- Word acceptance:
  - in_ready = (state==IDLE) || (out_valid && out_last && out_ready). This is combinational from registered state and out_ready, with no path from in_valid.
  - An input handshake (in_valid && in_ready) loads the shift register with in_data and sets remaining = in_nbeats.
  - The next state is SEND, with out_valid=1 on the following cycle.
- Latency: a word accepted at edge N has its first beat visible on out_data after edge N. There is no extra bubble.
- Beat selection:
  - LSB_FIRST=1: out_data = shift_reg[OUT_WIDTH-1:0]. Each accepted beat shifts right by OUT_WIDTH.
  - LSB_FIRST=0: out_data = shift_reg[IN_WIDTH-1 -: OUT_WIDTH]. Each accepted beat shifts left.
  - Vacated bits fill with 0.
- out_last = out_valid && (remaining==0). remaining decrements on each output handshake that is not the last beat.
- Completion of the last beat:
  - Last beat accepted with no simultaneous input handshake: go to IDLE, out_valid=0, out_last=0.
  - Last beat accepted together with an input handshake on the same edge: load the new word, stay in SEND, out_valid stays 1. This gives zero-bubble back-to-back words and 100% output throughput when out_ready is held at 1.
- Backpressure: while out_valid && !out_ready, out_data, out_last and the internal state are held stable. in_ready=0 in SEND except for the final-beat accept case.
- in_nbeats values above RATIO-1 (only possible for non-power-of-two RATIO) are clamped to RATIO-1.
- RATIO==1: every word is a single beat with out_last=1. The block then behaves as a one-deep registered stage.
- Reset mid-word: remaining beats are discarded. After deassertion the block is in IDLE with outputs at reset values; no partial beat is emitted.
- in_data and in_nbeats are ignored when no input handshake occurs.

Decomposition:
- Shared package stream_pkg holds:
  - the beat-order constants (LSB_FIRST_ORDER=1, MSB_FIRST_ORDER=0);
  - the state enum type ser_state_t {IDLE, SEND};
  - a function beats_cnt_w(int ratio) returning CNT_W.
- No sub-module is needed. The shift register, counter and two-state FSM stay in one module of roughly 150 lines.

Test Plan:
- Full word, out_ready=1: in_data=0xDDCCBBAA, in_nbeats=3 -> out_data AA, BB, CC, DD on four consecutive cycles; out_last only on DD; in_ready=1 on the DD cycle.
- Backpressure: same word, out_ready low for 3 cycles on beat BB -> BB held stable with out_valid=1; then CC, DD follow; no beat lost or duplicated.
- Partial word: in_data=0x44332211, in_nbeats=1 -> beats 11, 22 with out_last on 22; then IDLE (out_valid=0).
- Back-to-back: 0xDDCCBBAA then 0x44332211, both in_nbeats=3, in_valid and out_ready held high -> 8 contiguous beats AA..DD, 11..44 with no gap; out_last on DD and 44.
- MSB-first (LSB_FIRST=0): in_data=0xDDCCBBAA, in_nbeats=3 -> DD, CC, BB, AA; out_last on AA.
- Reset mid-word: assert rst_n=0 after beat BB is accepted -> out_valid=0 and in_ready=1 immediately after deassert; next word 0x44332211 starts cleanly with 11.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width-down-converter.
package stream_pkg;

    localparam int LSB_FIRST_ORDER = 1;
    localparam int MSB_FIRST_ORDER = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Beat counter width; never narrower than one bit, even when RATIO is 1.
    function automatic int beats_cnt_w(int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// Wide-word input and narrow-beat output handshakes of the serializer.
interface stream_serializer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_W     = 2
);
    logic [IN_WIDTH-1:0]  in_data;
    logic [CNT_W-1:0]     in_nbeats;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output in_data, in_nbeats, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_nbeats, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/stream_serializer.sv
// Splits one wide word into up to RATIO narrow beats, flagging the final beat with out_last.
module stream_serializer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int LSB_FIRST = LSB_FIRST_ORDER
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_serializer_if.slave bus
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = beats_cnt_w(RATIO);
    localparam logic [CNT_W-1:0] MAX_NBEATS = CNT_W'(RATIO - 1);

    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
        $error("stream_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (LSB_FIRST != LSB_FIRST_ORDER && LSB_FIRST != MSB_FIRST_ORDER) begin : g_bad_order
        $error("stream_serializer: LSB_FIRST must be 0 or 1");
    end

    ser_state_t           state_q;
    logic [IN_WIDTH-1:0]  shift_q;
    logic [IN_WIDTH-1:0]  shift_d;
    logic [CNT_W-1:0]     remaining_q;
    logic [CNT_W-1:0]     nbeats_d;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 in_ready;
    logic                 in_hs;
    logic                 out_hs;

    // A new word may enter while the last beat of the current one leaves, giving zero-bubble words.
    assign in_ready = (state_q == IDLE) || (out_valid_q && out_last_q && bus.out_ready);
    assign in_hs    = bus.in_valid && in_ready;
    assign out_hs   = out_valid_q && bus.out_ready;

    always_comb begin
        nbeats_d = (bus.in_nbeats > MAX_NBEATS) ? MAX_NBEATS : bus.in_nbeats;
        if (LSB_FIRST == LSB_FIRST_ORDER) begin
            shift_d = shift_q >> OUT_WIDTH;
        end else begin
            shift_d = shift_q << OUT_WIDTH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (in_hs) begin
            state_q     <= SEND;
            shift_q     <= bus.in_data;
            remaining_q <= nbeats_d;
            out_valid_q <= 1'b1;
            out_last_q  <= (nbeats_d == '0);
        end else if (out_hs) begin
            if (out_last_q) begin
                state_q     <= IDLE;
                shift_q     <= '0;
                remaining_q <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                shift_q     <= shift_d;
                remaining_q <= remaining_q - CNT_W'(1);
                out_last_q  <= (remaining_q == CNT_W'(1));
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    if (LSB_FIRST == LSB_FIRST_ORDER) begin : g_lsb_out
        assign bus.out_data = shift_q[OUT_WIDTH-1:0];
    end else begin : g_msb_out
        assign bus.out_data = shift_q[IN_WIDTH-1 -: OUT_WIDTH];
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench: an LSB-first and an MSB-first serializer driven with identical input traffic.
module tb_stream_serializer;
    import stream_pkg::*;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;

    stream_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8), .CNT_W(2)) busLsb ();
    stream_serializer_if #(.IN_WIDTH(32), .OUT_WIDTH(8), .CNT_W(2)) busMsb ();

    stream_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(LSB_FIRST_ORDER)) dutLsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busLsb.slave)
    );

    stream_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(MSB_FIRST_ORDER)) dutMsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busMsb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [1:0] nb,
                                 input logic ordy);
        busLsb.in_valid  = v;
        busLsb.in_data   = d;
        busLsb.in_nbeats = nb;
        busLsb.out_ready = ordy;
        busMsb.in_valid  = v;
        busMsb.in_data   = d;
        busMsb.in_nbeats = nb;
        busMsb.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkLsb(input string tag, input logic [7:0] d, input logic v, input logic l);
        checkOutput({tag, "_lsb_valid"}, 32'(busLsb.out_valid), 32'(v));
        checkOutput({tag, "_lsb_last"}, 32'(busLsb.out_last), 32'(l));
        if (v) checkOutput({tag, "_lsb_data"}, 32'(busLsb.out_data), 32'(d));
    endtask

    task automatic checkMsb(input string tag, input logic [7:0] d, input logic v, input logic l);
        checkOutput({tag, "_msb_valid"}, 32'(busMsb.out_valid), 32'(v));
        checkOutput({tag, "_msb_last"}, 32'(busMsb.out_last), 32'(l));
        if (v) checkOutput({tag, "_msb_data"}, 32'(busMsb.out_data), 32'(d));
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkLsb("reset", 8'h00, 1'b0, 1'b0);
        checkOutput("reset_data", 32'(busLsb.out_data), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(busLsb.in_ready), 32'h1);

        // Full word with the sink always ready; MSB-first twin reverses the order.
        applyStimulus(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        checkLsb("full_b0", 8'hAA, 1'b1, 1'b0);
        checkMsb("full_b0", 8'hDD, 1'b1, 1'b0);
        checkOutput("full_b0_in_ready", 32'(busLsb.in_ready), 32'h0);
        tick();
        checkLsb("full_b1", 8'hBB, 1'b1, 1'b0);
        checkMsb("full_b1", 8'hCC, 1'b1, 1'b0);
        tick();
        checkLsb("full_b2", 8'hCC, 1'b1, 1'b0);
        checkMsb("full_b2", 8'hBB, 1'b1, 1'b0);
        tick();
        checkLsb("full_b3", 8'hDD, 1'b1, 1'b1);
        checkMsb("full_b3", 8'hAA, 1'b1, 1'b1);
        checkOutput("full_b3_in_ready", 32'(busLsb.in_ready), 32'h1);
        tick();
        checkLsb("full_idle", 8'h00, 1'b0, 1'b0);
        checkMsb("full_idle", 8'h00, 1'b0, 1'b0);

        // Backpressure on beat BB for three edges.
        applyStimulus(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        checkLsb("bp_b0", 8'hAA, 1'b1, 1'b0);
        tick();
        checkLsb("bp_b1", 8'hBB, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0);
        #1;
        checkOutput("bp_in_ready", 32'(busLsb.in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkLsb($sformatf("bp_hold%0d", i), 8'hBB, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1);
        tick();
        checkLsb("bp_b2", 8'hCC, 1'b1, 1'b0);
        tick();
        checkLsb("bp_b3", 8'hDD, 1'b1, 1'b1);
        tick();
        checkLsb("bp_idle", 8'h00, 1'b0, 1'b0);

        // Partial word of two beats.
        applyStimulus(1'b1, 32'h44332211, 2'd1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        checkLsb("part_b0", 8'h11, 1'b1, 1'b0);
        checkMsb("part_b0", 8'h44, 1'b1, 1'b0);
        tick();
        checkLsb("part_b1", 8'h22, 1'b1, 1'b1);
        checkMsb("part_b1", 8'h33, 1'b1, 1'b1);
        tick();
        checkLsb("part_idle", 8'h00, 1'b0, 1'b0);
        checkOutput("part_idle_in_ready", 32'(busLsb.in_ready), 32'h1);

        // Back-to-back words with in_valid held high across the boundary.
        applyStimulus(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h44332211, 2'd3, 1'b1);
        #1;
        checkLsb("b2b_b0", 8'hAA, 1'b1, 1'b0);
        tick();
        checkLsb("b2b_b1", 8'hBB, 1'b1, 1'b0);
        tick();
        checkLsb("b2b_b2", 8'hCC, 1'b1, 1'b0);
        tick();
        checkLsb("b2b_b3", 8'hDD, 1'b1, 1'b1);
        checkOutput("b2b_b3_in_ready", 32'(busLsb.in_ready), 32'h1);
        tick();
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        checkLsb("b2b_b4", 8'h11, 1'b1, 1'b0);
        checkMsb("b2b_b4", 8'h44, 1'b1, 1'b0);
        tick();
        checkLsb("b2b_b5", 8'h22, 1'b1, 1'b0);
        tick();
        checkLsb("b2b_b6", 8'h33, 1'b1, 1'b0);
        tick();
        checkLsb("b2b_b7", 8'h44, 1'b1, 1'b1);
        checkMsb("b2b_b7", 8'h11, 1'b1, 1'b1);
        tick();
        checkLsb("b2b_idle", 8'h00, 1'b0, 1'b0);

        // Reset asserted after BB has been accepted; the rest of the word is dropped.
        applyStimulus(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        checkLsb("rst_b0", 8'hAA, 1'b1, 1'b0);
        tick();
        checkLsb("rst_b1", 8'hBB, 1'b1, 1'b0);
        tick();
        checkLsb("rst_b2", 8'hCC, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkLsb("rst_async", 8'h00, 1'b0, 1'b0);
        checkOutput("rst_async_data", 32'(busLsb.out_data), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        checkLsb("rst_after", 8'h00, 1'b0, 1'b0);
        checkOutput("rst_after_in_ready", 32'(busLsb.in_ready), 32'h1);
        tick();
        checkLsb("rst_no_partial", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h44332211, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        checkLsb("rst_new_b0", 8'h11, 1'b1, 1'b0);
        tick();
        checkLsb("rst_new_b1", 8'h22, 1'b1, 1'b0);
        tick();
        checkLsb("rst_new_b2", 8'h33, 1'b1, 1'b0);
        tick();
        checkLsb("rst_new_b3", 8'h44, 1'b1, 1'b1);
        tick();
        checkLsb("rst_new_idle", 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
